// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Tracks the destination registers of the instructions currently in the
// execute-side stages and, for the instruction sitting in ID, works out
// where each source operand must come from and whether ID has to stall.
// A multi-cycle (md) op freezes the whole tracker while it occupies stage 1.
//
// Ports
//   clk_i          : clock
//   rst_ni         : asynchronous active-low reset
//   id_valid_i     : a decoded instruction is presented in ID
//   id_rs_addr_i   : NUM_SRC packed 5-bit source register addresses
//   id_rd_i        : destination register of the ID instruction
//   id_reg_write_i : ID instruction writes id_rd_i
//   id_is_load_i   : ID instruction's result is only available from stage 2
//   id_is_md_i     : ID instruction is a multi-cycle op
//   flush_i        : kill the stage-1 record and the ID instruction
//   fwd_sel_o      : per source, 0 = register file, k = forward from stage k
//   stall_o        : hold PC/ID this cycle
//   md_busy_o      : a multi-cycle op is holding the pipeline
module hazard_scoreboard #(
   parameter  int NUM_FWD = 2,
   parameter  int NUM_SRC = 2,
   parameter  int MD_LAT  = 4,
   localparam int SELW    = $clog2(NUM_FWD + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      id_valid_i,
   input  logic [NUM_SRC*5-1:0]      id_rs_addr_i,
   input  logic [4:0]                id_rd_i,
   input  logic                      id_reg_write_i,
   input  logic                      id_is_load_i,
   input  logic                      id_is_md_i,
   input  logic                      flush_i,
   output logic [NUM_SRC*SELW-1:0]   fwd_sel_o,
   output logic                      stall_o,
   output logic                      md_busy_o
);

   localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

   // Index 0 holds stage 1 (EX), index NUM_FWD-1 the oldest tracked stage.
   logic [NUM_FWD-1:0] vld_q;
   logic [NUM_FWD-1:0] wr_q;
   logic [NUM_FWD-1:0] ld_q;
   logic [4:0]         rd_q [NUM_FWD];
   logic [CW-1:0]      md_cnt_q;

   logic                    md_busy;
   logic                    hazard;
   logic                    issue;
   logic [NUM_SRC*SELW-1:0] fwd_sel;

   // A non-zero counter means the md op in stage 1 is still computing and
   // everything is frozen around it.
   assign md_busy = (md_cnt_q != '0);

   // Forwarding select and hazard detection. The stage loop runs from oldest
   // to youngest so the youngest match is the one that sticks. Only stage 1
   // can be not-ready: a load there has no data yet, and an md op there has
   // no data while its counter is running. Destination x0 never matches,
   // which also keeps x0 sources away from forwarding and stalls.
   always_comb begin
      fwd_sel = '0;
      hazard  = 1'b0;
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (vld_q[k] && wr_q[k] && (rd_q[k] != 5'd0) &&
                (rd_q[k] == id_rs_addr_i[s*5 +: 5])) begin
               fwd_sel[s*SELW +: SELW] = SELW'(k + 1);
            end
         end
         if ((fwd_sel[s*SELW +: SELW] == SELW'(1)) && (ld_q[0] || md_busy)) begin
            hazard = 1'b1;
         end
      end
   end

   assign stall_o   = md_busy || (id_valid_i && hazard);
   assign issue     = id_valid_i && !stall_o && !flush_i;
   assign fwd_sel_o = fwd_sel;
   assign md_busy_o = md_busy;

   // Record pipeline. Outside a freeze every stage shifts and stage 1 takes
   // the issued instruction or a bubble. A flush both shifts (even mid
   // freeze) and kills the record leaving stage 1, so it shows up as a bubble
   // in stage 2 rather than as a live forwarding source. During a freeze the
   // records hold and only the counter moves.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q    <= '0;
         wr_q     <= '0;
         ld_q     <= '0;
         md_cnt_q <= '0;
         for (int k = 0; k < NUM_FWD; k++) begin
            rd_q[k] <= 5'd0;
         end
      end else if (!md_busy || flush_i) begin
         for (int k = 1; k < NUM_FWD; k++) begin
            vld_q[k] <= vld_q[k-1] && !(flush_i && (k == 1));
            wr_q[k]  <= wr_q[k-1];
            ld_q[k]  <= ld_q[k-1];
            rd_q[k]  <= rd_q[k-1];
         end
         vld_q[0] <= issue;
         wr_q[0]  <= id_reg_write_i;
         ld_q[0]  <= id_is_load_i;
         rd_q[0]  <= id_rd_i;
         md_cnt_q <= (issue && id_is_md_i) ? CW'(MD_LAT - 1) : '0;
      end else begin
         md_cnt_q <= md_cnt_q - CW'(1);
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Drives directed hazard scenarios followed by randomized traffic into
// hazard_scoreboard. Every driven cycle pushes the expected outputs from a
// queue-based pipeline model into a scoreboard queue; a monitor on the
// falling clock edge pops and compares against the DUT.
module tb_hazard_scoreboard;

   localparam int NUM_FWD = 2;
   localparam int NUM_SRC = 2;
   localparam int MD_LAT  = 4;
   localparam int SELW    = 2;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b1;
   logic                    id_valid = 1'b0;
   logic [NUM_SRC*5-1:0]    id_rs_addr = '0;
   logic [4:0]              id_rd = '0;
   logic                    id_reg_write = 1'b0;
   logic                    id_is_load = 1'b0;
   logic                    id_is_md = 1'b0;
   logic                    flush = 1'b0;
   logic [NUM_SRC*SELW-1:0] fwd_sel;
   logic                    stall;
   logic                    md_busy;

   hazard_scoreboard #(
      .NUM_FWD(NUM_FWD),
      .NUM_SRC(NUM_SRC),
      .MD_LAT (MD_LAT)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .id_valid_i    (id_valid),
      .id_rs_addr_i  (id_rs_addr),
      .id_rd_i       (id_rd),
      .id_reg_write_i(id_reg_write),
      .id_is_load_i  (id_is_load),
      .id_is_md_i    (id_is_md),
      .flush_i       (flush),
      .fwd_sel_o     (fwd_sel),
      .stall_o       (stall),
      .md_busy_o     (md_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       wr;
      bit       ld;
   } rec_t;

   typedef struct {
      bit [3:0] sel;
      bit       stall;
      bit       busy;
      int       cyc;
   } exp_t;

   // Model: pipe[0] is stage 1; freeze_left counts remaining frozen cycles.
   rec_t pipe[$];
   int   freeze_left;
   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic void modelReset();
      rec_t empty;
      empty = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
      pipe.delete();
      for (int i = 0; i < NUM_FWD; i++) pipe.push_back(empty);
      freeze_left = 0;
   endfunction

   // Drive one ID cycle, predict the outputs for it, then advance the model
   // by the clock edge that ends this cycle.
   task automatic driveCycle(input bit v, input bit [4:0] rs0, input bit [4:0] rs1,
                             input bit [4:0] rd, input bit wr, input bit ld,
                             input bit md, input bit fl);
      exp_t     e;
      rec_t     nr;
      bit [4:0] rs [2];
      int       sel [2];
      bit       notready;
      bit       iss;
      id_valid     = v;
      id_rs_addr   = {rs1, rs0};
      id_rd        = rd;
      id_reg_write = wr;
      id_is_load   = ld;
      id_is_md     = md;
      flush        = fl;
      rs[0]    = rs0;
      rs[1]    = rs1;
      notready = 1'b0;
      e.busy   = (freeze_left > 0);
      for (int s = 0; s < 2; s++) begin
         sel[s] = 0;
         for (int k = 0; k < NUM_FWD; k++) begin
            if (sel[s] == 0 && pipe[k].v && pipe[k].wr && pipe[k].rd != 5'd0 && pipe[k].rd == rs[s])
               sel[s] = k + 1;
         end
         if (sel[s] == 1 && (pipe[0].ld || freeze_left > 0)) notready = 1'b1;
      end
      e.sel   = {2'(sel[1]), 2'(sel[0])};
      e.stall = e.busy || (v && notready);
      e.cyc   = cyc;
      exp_q.push_back(e);
      nr = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
      if (fl) begin
         pipe[0].v = 1'b0;
         pipe.push_front(nr);
         void'(pipe.pop_back());
         freeze_left = 0;
      end else if (e.busy) begin
         freeze_left--;
      end else begin
         iss = v && !e.stall;
         nr  = '{v: iss, rd: rd, wr: wr, ld: ld};
         pipe.push_front(nr);
         void'(pipe.pop_back());
         if (iss && md) freeze_left = MD_LAT - 1;
      end
      cyc++;
   endtask

   task automatic applyStimulus(input bit v, input bit [4:0] rs0, input bit [4:0] rs1,
                                input bit [4:0] rd, input bit wr, input bit ld,
                                input bit md, input bit fl);
      @(posedge clk);
      #2;
      driveCycle(v, rs0, rs1, rd, wr, ld, md, fl);
   endtask

   task automatic checkNow(input string name, input int s0, input int s1, input int st, input int bz);
      #1;
      checkOutput({name, "_sel0"},  8'(fwd_sel[1:0]), 8'(s0));
      checkOutput({name, "_sel1"},  8'(fwd_sel[3:2]), 8'(s1));
      checkOutput({name, "_stall"}, 8'(stall),        8'(st));
      checkOutput({name, "_busy"},  8'(md_busy),      8'(bz));
   endtask

   task automatic idle2();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Scoreboard monitor: compares one queued expectation per cycle, well
   // away from the rising edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput($sformatf("sb_sel@%0d", e.cyc),   8'(fwd_sel), 8'(e.sel));
         checkOutput($sformatf("sb_stall@%0d", e.cyc), 8'(stall),   8'(e.stall));
         checkOutput($sformatf("sb_busy@%0d", e.cyc),  8'(md_busy), 8'(e.busy));
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      modelReset();
      #1 rst_n = 1'b0;
      id_valid   = 1'b1;
      id_rs_addr = {5'd5, 5'd5};
      checkNow("reset", 0, 0, 0, 0);

      @(posedge clk);
      #2;
      rst_n = 1'b1;
      modelReset();
      driveCycle(0, 0, 0, 0, 0, 0, 0, 0);

      // Back-to-back ALU dependency
      applyStimulus(1, 0, 0, 5, 1, 0, 0, 0); checkNow("b2b_writer", 0, 0, 0, 0);
      applyStimulus(1, 5, 0, 0, 0, 0, 0, 0); checkNow("b2b_sel1",   1, 0, 0, 0);
      applyStimulus(1, 5, 0, 0, 0, 0, 0, 0); checkNow("b2b_sel2",   2, 0, 0, 0);
      idle2();

      // Load-use on rs2
      applyStimulus(1, 0, 0, 7, 1, 1, 0, 0); checkNow("lu_load",   0, 0, 0, 0);
      applyStimulus(1, 0, 7, 0, 0, 0, 0, 0); checkNow("lu_stall",  0, 1, 1, 0);
      applyStimulus(1, 0, 7, 0, 0, 0, 0, 0); checkNow("lu_resume", 0, 2, 0, 0);
      idle2();

      // Youngest writer wins
      applyStimulus(1, 0, 0, 3, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 3, 1, 0, 0, 0);
      applyStimulus(1, 3, 3, 0, 0, 0, 0, 0); checkNow("youngest", 1, 1, 0, 0);
      idle2();

      // Multi-cycle freeze
      applyStimulus(1, 0, 0, 9, 1, 0, 1, 0); checkNow("md_issue", 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 9, 0, 0, 0, 0, 0, 0);
         checkNow($sformatf("md_frozen%0d", i), 1, 0, 1, 1);
      end
      applyStimulus(1, 9, 0, 0, 0, 0, 0, 0); checkNow("md_release", 1, 0, 0, 0);
      idle2();

      // Flush during freeze
      applyStimulus(1, 0, 0, 9, 1, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); checkNow("fl_busy1", 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1); checkNow("fl_busy2", 0, 0, 1, 1);
      applyStimulus(1, 9, 0, 0, 0, 0, 0, 0); checkNow("fl_after", 0, 0, 0, 0);
      idle2();

      // x0 never forwards or stalls
      applyStimulus(1, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 1, 0, 0); checkNow("x0_read",       0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0); checkNow("x0_after_load", 0, 0, 0, 0);
      idle2();

      // Reset in the middle of a freeze
      applyStimulus(1, 0, 0, 9, 1, 0, 1, 0);
      applyStimulus(1, 9, 0, 0, 0, 0, 0, 0); checkNow("rst_pre", 1, 0, 1, 1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      checkNow("rst_async", 0, 0, 0, 0);
      @(posedge clk);
      #2;
      checkNow("rst_hold", 0, 0, 0, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      modelReset();
      driveCycle(1, 0, 0, 5, 1, 0, 0, 0); checkNow("rst_release", 0, 0, 0, 0);
      applyStimulus(1, 5, 0, 0, 0, 0, 0, 0); checkNow("rst_first_issue", 1, 0, 0, 0);

      // Randomized traffic on a small register set to provoke hazards
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 9) < 8,
                       5'($urandom_range(0, 4)),
                       5'($urandom_range(0, 4)),
                       5'($urandom_range(0, 4)),
                       $urandom_range(0, 9) < 8,
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 9) == 0,
                       $urandom_range(0, 19) == 0);
      end

      repeat (2) @(negedge clk);
      #1;
      checkOutput("sb_drain", 8'(exp_q.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
